clk_fault_supervisor: RTL and testbench
=======================================

# clk_fault_supervisor

Fault-handling stage directly downstream of the clock period/glitch monitor, in the `clk_ref` domain. The monitor's `fault` output is sticky, so this block re-arms it by pulsing its reset after each event. It counts faults inside a sliding window and escalates to a clock-switchover request plus interrupt when the count reaches a threshold. Software acknowledges the alarm and later restores the primary clock.

## Interface
Parameters:
- `FAULT_THRESH`, default 4: faults within one window that trigger ALARM; legal range 1..15.
- `WINDOW`, default 1024: window length in `clk_ref` cycles, counted from the first fault of the window; must be ≥ 2.
- `REARM_CYCLES`, default 2: cycles `mon_rst_n` is held low per re-arm; must be ≥ 1.
- `HOLDOFF_CYCLES`, default 4: cycles after re-arm release during which `fault_in` is ignored; must be ≥ 1.
- `CW`, default 16: width of the total event counter.

Ports:
- `clk_ref`  in  1: reference clock, shared with the monitor.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `fault_in`  in  1: monitor `fault`; synchronous to `clk_ref`; level, sticky until the monitor is reset.
- `sw_ack`  in  1: single-cycle pulse; acknowledges ALARM.
- `sw_restore`  in  1: single-cycle pulse; returns to the primary clock.
- `mon_rst_n`  out  1: registered active-low reset to the monitor.
- `sel_backup`  out  1: 1 selects the backup clock.
- `irq`  out  1: level interrupt; high while in ALARM.
- `warn`  out  1: high while `fault_cnt != 0`.
- `fault_cnt`  out  4: faults in the current window.
- `total_cnt`  out  CW: lifetime faults; saturates at all-ones.

## Operation
- The FSM has four states: REARM, HOLDOFF, ARMED and ALARM. Reset enters REARM with the phase counter at 0.
- Output values during reset:
  - `mon_rst_n` = 0.
  - `sel_backup` = 0, `irq` = 0, `warn` = 0.
  - `fault_cnt` = 0, `total_cnt` = 0.
- REARM:
  - `mon_rst_n` = 0 for exactly `REARM_CYCLES` cycles.
  - Then go to HOLDOFF, with `mon_rst_n` = 1 from the first HOLDOFF cycle.
- HOLDOFF:
  - Lasts `HOLDOFF_CYCLES` cycles; `fault_in` is ignored.
  - Then go to ARMED.
- ARMED, when `fault_in` = 1 in a cycle:
  - `total_cnt` increments (saturating).
  - `fault_cnt` increments.
  - If the new `fault_cnt` == `FAULT_THRESH`, go to ALARM; otherwise go to REARM.
- ALARM:
  - `sel_backup` = 1, `irq` = 1, and `mon_rst_n` = 0, which holds the monitor in reset.
  - `sw_ack` sets `irq` = 0, clears `fault_cnt` and the window counter, and goes to REARM.
  - `sel_backup` stays 1 after `sw_ack`.
- `sw_restore` is honoured only in ARMED, where it clears `sel_backup`. It is ignored in every other state.
- Window counter:
  - Runs while `fault_cnt != 0` and the state is not ALARM.
  - Reaching `WINDOW-1` clears both `fault_cnt` and the window counter.
- Fault accepted in the same cycle the window expires: it counts as the first fault of a new window. `fault_cnt` becomes 1, the window counter becomes 0, and the threshold check uses 1.
- A `fault_in` that is still high when ARMED is re-entered is a new fault; the monitor has been reset, so this means a genuinely new event.
- `sw_ack` and `sw_restore` asserted together: `sw_ack` acts (only in ALARM) and `sw_restore` is ignored.
- `rst_n` asserted mid-operation returns everything to the reset values, including `sel_backup` = 0.

## Timing
- All outputs are registered.
- From `fault_in` sampled high in ARMED to `mon_rst_n` low and the updated `fault_cnt`/`total_cnt` visible: 1 cycle.
- Same latency, 1 cycle, from the threshold fault to `irq`/`sel_backup` high.
- Earliest next fault accepted after a non-alarm fault: `1 + REARM_CYCLES + HOLDOFF_CYCLES` cycles later, which is 7 with the defaults.
- From `sw_ack` to `irq` low and the FSM in REARM: 1 cycle.
- From `sw_restore` in ARMED to `sel_backup` low: 1 cycle.
- After `rst_n` deassertion: `mon_rst_n` rises after `REARM_CYCLES` cycles, and the block is ARMED `REARM_CYCLES + HOLDOFF_CYCLES` cycles after deassertion.

## Test plan
- Reset release with `fault_in` = 0: `mon_rst_n` is low for 2 cycles, the block is ARMED at cycle 6, and all counts stay 0.
- Three faults spaced 20 cycles apart (defaults): `fault_cnt` reads 1, 2, 3; `total_cnt` = 3; three 2-cycle `mon_rst_n` pulses; no ALARM.
- Fourth fault within 1024 cycles: `irq` = 1, `sel_backup` = 1, `mon_rst_n` held 0. Then `sw_ack` → `irq` = 0, `fault_cnt` = 0, ARMED 6 cycles later with `sel_backup` still 1. Then `sw_restore` → `sel_backup` = 0.
- One fault, then none for 1024 cycles: `fault_cnt` returns to 0 and `warn` drops. A fault landing on the exact expiry cycle leaves `fault_cnt` = 1.
- `fault_in` held high permanently: one fault is counted every 7 cycles, and ALARM is reached on the 4th.
- `CW` = 4 with 20 faults, acking each alarm: `total_cnt` saturates at 15. Asserting `rst_n` during ALARM clears all outputs.

Source files
------------

// File: rtl/clk_fault_supervisor.sv
// Fault-handling stage behind the clock period/glitch monitor (clk_ref domain).
// Re-arms the sticky monitor fault by pulsing its reset, counts faults in a
// sliding window and escalates to backup-clock select + interrupt at threshold.
module clk_fault_supervisor #(
   parameter int FAULT_THRESH   = 4,
   parameter int WINDOW         = 1024,
   parameter int REARM_CYCLES   = 2,
   parameter int HOLDOFF_CYCLES = 4,
   parameter int CW             = 16
) (
   input  logic          clk_ref,
   input  logic          rst_n,
   input  logic          fault_in,
   input  logic          sw_ack,
   input  logic          sw_restore,
   output logic          mon_rst_n,
   output logic          sel_backup,
   output logic          irq,
   output logic          warn,
   output logic [3:0]    fault_cnt,
   output logic [CW-1:0] total_cnt
);

   localparam int PMAX = (REARM_CYCLES > HOLDOFF_CYCLES) ? REARM_CYCLES : HOLDOFF_CYCLES;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int WW   = $clog2(WINDOW);

   typedef enum logic [1:0] {S_REARM, S_HOLDOFF, S_ARMED, S_ALARM} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [3:0]      fcnt_q, fcnt_d, fcnt_new;
   logic [WW-1:0]   win_q, win_d;
   logic [CW-1:0]   total_q, total_d;
   logic            sel_q, sel_d;
   logic            mon_q, mon_d;
   logic            irq_q, irq_d;
   logic            warn_q, warn_d;
   logic            win_run, win_exp;

   // Next-state: window aging, phase sequencing, fault acceptance, escalation.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      fcnt_d   = fcnt_q;
      win_d    = win_q;
      total_d  = total_q;
      sel_d    = sel_q;
      fcnt_new = 4'd0;

      // Window ages only while faults are outstanding; frozen during ALARM
      // because the ack clears it anyway.
      win_run = (fcnt_q != 4'd0) && (state_q != S_ALARM);
      win_exp = win_run && (win_q == WW'(WINDOW - 1));
      if (win_exp) begin
         fcnt_d = 4'd0;
         win_d  = '0;
      end else if (win_run) begin
         win_d = win_q + 1'b1;
      end

      case (state_q)
         S_REARM: begin
            if (phase_q == PW'(REARM_CYCLES - 1)) begin
               state_d = S_HOLDOFF;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_HOLDOFF: begin
            if (phase_q == PW'(HOLDOFF_CYCLES - 1)) begin
               state_d = S_ARMED;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_ARMED: begin
            if (sw_restore) sel_d = 1'b0;
            if (fault_in) begin
               if (total_q != {CW{1'b1}}) total_d = total_q + 1'b1;
               // A fault on the expiry cycle opens a fresh window.
               fcnt_new = win_exp ? 4'd1 : (fcnt_q + 4'd1);
               fcnt_d   = fcnt_new;
               phase_d  = '0;
               if (fcnt_new == 4'(FAULT_THRESH)) begin
                  state_d = S_ALARM;
                  sel_d   = 1'b1;
               end else begin
                  state_d = S_REARM;
               end
            end
         end
         S_ALARM: begin
            if (sw_ack) begin
               state_d = S_REARM;
               phase_d = '0;
               fcnt_d  = 4'd0;
               win_d   = '0;
            end
         end
         default: begin
            state_d = S_REARM;
            phase_d = '0;
         end
      endcase

      mon_d  = (state_d == S_HOLDOFF) || (state_d == S_ARMED);
      irq_d  = (state_d == S_ALARM);
      warn_d = (fcnt_d != 4'd0);
   end

   // State and registered outputs; reset holds the monitor in reset.
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REARM;
         phase_q <= '0;
         fcnt_q  <= 4'd0;
         win_q   <= '0;
         total_q <= '0;
         sel_q   <= 1'b0;
         mon_q   <= 1'b0;
         irq_q   <= 1'b0;
         warn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         fcnt_q  <= fcnt_d;
         win_q   <= win_d;
         total_q <= total_d;
         sel_q   <= sel_d;
         mon_q   <= mon_d;
         irq_q   <= irq_d;
         warn_q  <= warn_d;
      end
   end

   assign mon_rst_n  = mon_q;
   assign sel_backup = sel_q;
   assign irq        = irq_q;
   assign warn       = warn_q;
   assign fault_cnt  = fcnt_q;
   assign total_cnt  = total_q;

endmodule

// File: tb/tb_clk_fault_supervisor.sv
// Bench for clk_fault_supervisor: a default instance and a CW=4 instance share
// stimulus; a timeline-based model (edge indices, not states) predicts outputs.
module tb_clk_fault_supervisor;

   localparam int T  = 4;
   localparam int W  = 1024;
   localparam int R  = 2;
   localparam int H  = 4;

   logic clk_ref = 1'b0;
   logic rst_n = 1'b0;
   logic fault_in = 1'b0, sw_ack = 1'b0, sw_restore = 1'b0;

   logic mon_rst_n, sel_backup, irq, warn;
   logic [3:0]  fault_cnt;
   logic [15:0] total_cnt;
   logic mon4, sel4, irq4, warn4;
   logic [3:0] fcnt4, tot4;

   always #5 clk_ref = ~clk_ref;

   clk_fault_supervisor dut (
      .clk_ref(clk_ref), .rst_n(rst_n), .fault_in(fault_in), .sw_ack(sw_ack),
      .sw_restore(sw_restore), .mon_rst_n(mon_rst_n), .sel_backup(sel_backup),
      .irq(irq), .warn(warn), .fault_cnt(fault_cnt), .total_cnt(total_cnt));

   clk_fault_supervisor #(.CW(4)) dut4 (
      .clk_ref(clk_ref), .rst_n(rst_n), .fault_in(fault_in), .sw_ack(sw_ack),
      .sw_restore(sw_restore), .mon_rst_n(mon4), .sel_backup(sel4),
      .irq(irq4), .warn(warn4), .fault_cnt(fcnt4), .total_cnt(tot4));

   int n_checks = 0;
   int n_fail   = 0;

   // Model: everything expressed as edge indices since reset release.
   int m_e, m_s, m_armed_at, m_wfirst, m_fcnt, m_tot, m_tot4;
   bit m_alarm, m_sel;

   logic [35:0] obs;
   assign obs = {mon_rst_n, sel_backup, irq, warn, fault_cnt, total_cnt,
                 mon4, sel4, irq4, warn4, fcnt4, tot4};

   function automatic logic [35:0] exp_vec();
      logic [7:0] c;
      logic mon;
      mon = !m_alarm && (m_e >= m_s + R);
      c = {mon, m_sel, m_alarm, (m_fcnt != 0), 4'(m_fcnt)};
      return {c, 16'(m_tot), c, 4'(m_tot4)};
   endfunction

   function automatic bit m_armed();
      return !m_alarm && (m_e >= m_armed_at);
   endfunction

   task automatic model_reset();
      m_e = 0; m_s = 0; m_armed_at = R + H; m_wfirst = 0;
      m_fcnt = 0; m_tot = 0; m_tot4 = 0; m_alarm = 0; m_sel = 0;
   endtask

   task automatic model_edge(input bit f, input bit a, input bit r);
      bit was_alarm, armed, expire;
      m_e++;
      was_alarm = m_alarm;
      armed  = !m_alarm && (m_e - 1 >= m_armed_at);
      expire = !m_alarm && (m_fcnt != 0) && (m_e == m_wfirst + W);
      if (expire) m_fcnt = 0;
      if (armed && r) m_sel = 0;
      if (armed && f) begin
         if (m_tot < 65535) m_tot++;
         if (m_tot4 < 15) m_tot4++;
         if (m_fcnt == 0) begin
            m_fcnt = 1;
            m_wfirst = m_e;
         end else m_fcnt++;
         if (m_fcnt == T) begin
            m_alarm = 1;
            m_sel = 1;
         end else begin
            m_s = m_e;
            m_armed_at = m_e + R + H;
         end
      end
      if (was_alarm && a) begin
         m_alarm = 0;
         m_fcnt = 0;
         m_s = m_e;
         m_armed_at = m_e + R + H;
      end
   endtask

   // Drive inputs, take one clock edge, advance the model, settle.
   task automatic tick(input bit f, input bit a, input bit r);
      fault_in = f; sw_ack = a; sw_restore = r;
      @(posedge clk_ref);
      model_edge(f, a, r);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fault_in = 1'b0; sw_ack = 1'b0; sw_restore = 1'b0;
      #2;
      n_checks++;
      if (obs !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", obs, 36'h0);
      end
      @(negedge clk_ref);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick(0, 0, 0);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_seq cyc%0d: got %h want %h", i, obs, exp_vec());
         end
         if (i == 2 || i == 1) begin
            n_checks++;
            if (mon_rst_n !== (i == 2)) begin
               n_fail++;
               $display("FAIL reset_mon_rst_n cyc%0d: got %b want %b", i, mon_rst_n, i == 2);
            end
         end
      end
   endtask

   task automatic test_spaced_faults();
      for (int k = 1; k <= 3; k++) begin
         tick(1, 0, 0);
         n_checks++;
         if (fault_cnt !== 4'(k) || mon_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL spaced_fault%0d: got cnt=%0d mon=%b want cnt=%0d mon=0",
                     k, fault_cnt, mon_rst_n, k);
         end
         for (int i = 0; i < 19; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL spaced_seq: got %h want %h", obs, exp_vec());
            end
         end
      end
      n_checks++;
      if (total_cnt !== 16'd3 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL spaced_total: got tot=%0d irq=%b want tot=3 irq=0", total_cnt, irq);
      end
   endtask

   task automatic test_alarm();
      int n;
      tick(1, 0, 0);
      n_checks++;
      if ({irq, sel_backup, mon_rst_n} !== 3'b110) begin
         n_fail++;
         $display("FAIL alarm_entry: got irq/sel/mon=%b want 110", {irq, sel_backup, mon_rst_n});
      end
      for (int i = 0; i < 5; i++) tick(0, 0, 0);
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL alarm_hold: got %h want %h", obs, exp_vec());
      end
      tick(0, 1, 1);
      n_checks++;
      if (irq !== 1'b0 || fault_cnt !== 4'd0 || sel_backup !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_ack: got irq=%b cnt=%0d sel=%b want 0 0 1", irq, fault_cnt, sel_backup);
      end
      n = 0;
      while (!m_armed() && n < 20) begin
         tick(0, 0, 1);
         n++;
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL ack_rearm: got %h want %h", obs, exp_vec());
         end
      end
      n_checks++;
      if (n != R + H || sel_backup !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_to_armed: got %0d cycles sel=%b want 6 cycles sel=1", n, sel_backup);
      end
      tick(0, 0, 1);
      n_checks++;
      if (sel_backup !== 1'b0) begin
         n_fail++;
         $display("FAIL restore: got sel=%b want 0", sel_backup);
      end
   endtask

   task automatic test_window();
      int n = 0;
      tick(1, 0, 0);
      while (m_fcnt != 0 && n < 1100) begin
         tick(0, 0, 0);
         n++;
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL window_seq: got %h want %h", obs, exp_vec());
         end
      end
      n_checks++;
      if (n != W || fault_cnt !== 4'd0 || warn !== 1'b0) begin
         n_fail++;
         $display("FAIL window_expire: got %0d cycles cnt=%0d warn=%b want 1024 0 0", n, fault_cnt, warn);
      end
      tick(1, 0, 0);
      tick(1, 0, 0);
      n = 0;
      while (m_e + 1 != m_wfirst + W && n < 1100) begin
         tick(0, 0, 0);
         n++;
      end
      tick(1, 0, 0);
      n_checks++;
      if (fault_cnt !== 4'd1 || irq !== 1'b0 || obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL window_edge_fault: got cnt=%0d irq=%b (%h) want cnt=1 irq=0 (%h)",
                  fault_cnt, irq, obs, exp_vec());
      end
   endtask

   task automatic test_stuck_fault();
      do_reset();
      for (int i = 1; i <= 32; i++) begin
         tick(1, 0, 0);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL stuck_seq cyc%0d: got %h want %h", i, obs, exp_vec());
         end
         if (i == 27 || i == 28) begin
            n_checks++;
            if (irq !== (i == 28) || fault_cnt !== 4'(i == 28 ? 4 : 3)) begin
               n_fail++;
               $display("FAIL stuck_alarm cyc%0d: got irq=%b cnt=%0d", i, irq, fault_cnt);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int n = 0;
      do_reset();
      while (!(m_tot == 20 && m_alarm) && n < 600) begin
         tick(1, m_alarm, 0);
         n++;
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL sat_seq: got %h want %h", obs, exp_vec());
         end
      end
      n_checks++;
      if (total_cnt !== 16'd20 || tot4 !== 4'd15 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL saturation: got tot=%0d tot4=%0d irq=%b want 20 15 1", total_cnt, tot4, irq);
      end
      do_reset();
   endtask

   task automatic test_random();
      bit f, a, r;
      for (int i = 0; i < 6000; i++) begin
         if (i < 2000) f = ($urandom_range(0, 9) == 0);
         else f = ($urandom_range(0, 299) == 0);
         a = m_alarm ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1999) == 0) do_reset();
         else begin
            tick(f, a, r);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_vec());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_spaced_faults();
      test_alarm();
      test_window();
      test_stuck_fault();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
